// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep/hop scheduler: steps the NCO phase increment every dwell
// period and streams it to the phase accumulator with a valid strobe.
module nco_sweep_ctrl #(
  parameter int PW = 32,
  parameter int NW = 12,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_valid_i,
  output logic          cfg_ready_o,
  input  logic [PW-1:0] cfg_start_i,
  input  logic [PW-1:0] cfg_step_i,
  input  logic [NW-1:0] cfg_nsteps_i,
  input  logic [DW-1:0] cfg_dwell_i,
  input  logic          cfg_loop_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic [PW-1:0] p_inc_o,
  output logic          valid_o,
  output logic [NW-1:0] step_idx_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [PW-1:0] start_q;
  logic [PW-1:0] step_q;
  logic [NW-1:0] last_idx_q;
  logic [DW-1:0] last_dwell_q;
  logic          loop_q;
  logic          cfg_loaded;
  logic [DW-1:0] dwell_cnt;

  logic          cfg_hs;
  logic          launch;
  logic [NW-1:0] last_idx_new;
  logic [DW-1:0] last_dwell_new;

  // Counts are stored as "last index" so a programmed 0 behaves like 1.
  assign last_idx_new   = (cfg_nsteps_i == '0) ? '0 : cfg_nsteps_i - NW'(1);
  assign last_dwell_new = (cfg_dwell_i == '0) ? '0 : cfg_dwell_i - DW'(1);
  assign cfg_hs         = (state == IDLE) && cfg_valid_i && cfg_ready_o;
  assign launch         = (state == IDLE) && start_i && (cfg_loaded || cfg_hs);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      start_q      <= '0;
      step_q       <= '0;
      last_idx_q   <= '0;
      last_dwell_q <= '0;
      loop_q       <= 1'b0;
      cfg_loaded   <= 1'b0;
      dwell_cnt    <= '0;
      cfg_ready_o  <= 1'b0;
      p_inc_o      <= '0;
      valid_o      <= 1'b0;
      step_idx_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          cfg_ready_o <= 1'b1;
          if (cfg_hs) begin
            start_q      <= cfg_start_i;
            step_q       <= cfg_step_i;
            last_idx_q   <= last_idx_new;
            last_dwell_q <= last_dwell_new;
            loop_q       <= cfg_loop_i;
            cfg_loaded   <= 1'b1;
          end
          // A config presented alongside start takes effect for this sweep.
          if (launch) begin
            state       <= RUN;
            p_inc_o     <= cfg_hs ? cfg_start_i : start_q;
            step_idx_o  <= '0;
            dwell_cnt   <= '0;
            valid_o     <= 1'b1;
            busy_o      <= 1'b1;
            cfg_ready_o <= 1'b0;
          end
        end

        RUN: begin
          if (abort_i) begin
            state       <= IDLE;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            cfg_ready_o <= 1'b1;
          end else if (dwell_cnt != last_dwell_q) begin
            dwell_cnt <= dwell_cnt + DW'(1);
          end else begin
            dwell_cnt <= '0;
            if (step_idx_o != last_idx_q) begin
              p_inc_o    <= p_inc_o + step_q;
              step_idx_o <= step_idx_o + NW'(1);
            end else if (loop_q) begin
              p_inc_o    <= start_q;
              step_idx_o <= '0;
            end else begin
              state   <= DONE;
              done_o  <= 1'b1;
              valid_o <= 1'b0;
              busy_o  <= 1'b0;
            end
          end
        end

        DONE: begin
          state       <= IDLE;
          cfg_ready_o <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          valid_o     <= 1'b0;
          busy_o      <= 1'b0;
          cfg_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed and random sweeps checked
// against an arithmetic model of the expected increment sequence.
module tb_nco_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_start;
  logic [31:0] cfg_step;
  logic [11:0] cfg_nsteps;
  logic [15:0] cfg_dwell;
  logic        cfg_loop;
  logic        start;
  logic        abort;
  logic [31:0] p_inc;
  logic        valid;
  logic [11:0] step_idx;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_start;
  logic [31:0] m_step;
  int          m_nsteps;
  int          m_dwell;
  bit          m_loop;

  nco_sweep_ctrl #(.PW(32), .NW(12), .DW(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_start_i(cfg_start), .cfg_step_i(cfg_step),
    .cfg_nsteps_i(cfg_nsteps), .cfg_dwell_i(cfg_dwell), .cfg_loop_i(cfg_loop),
    .start_i(start), .abort_i(abort),
    .p_inc_o(p_inc), .valid_o(valid), .step_idx_o(step_idx),
    .busy_o(busy), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present a config word (optionally with start in the same cycle).
  task automatic do_cfg(input logic [31:0] s, input logic [31:0] st, input int n,
                        input int d, input bit lp, input bit with_start);
    cfg_start  = s;
    cfg_step   = st;
    cfg_nsteps = 12'(n);
    cfg_dwell  = 16'(d);
    cfg_loop   = lp;
    cfg_valid  = 1'b1;
    start      = with_start;
    tests++;
    if (cfg_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL cfg_ready_in_idle: got %b expected 1", cfg_ready);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    start     = 1'b0;
    m_start   = s;
    m_step    = st;
    m_nsteps  = (n == 0) ? 1 : n;
    m_dwell   = (d == 0) ? 1 : d;
    m_loop    = lp;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Check RUN cycles k = 0..ncyc-1; frequency index is floor(k/dwell) mod nsteps.
  task automatic check_run(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      int          idx;
      logic [31:0] exp_p;
      idx   = (k / m_dwell) % m_nsteps;
      exp_p = m_start + m_step * 32'(idx);
      tests++;
      if ({valid, busy, done, cfg_ready} !== 4'b1100 || p_inc !== exp_p ||
          step_idx !== 12'(idx)) begin
        fails++;
        $display("[TB] FAIL run k=%0d: vbdr=%b p_inc=%h idx=%0d, expected vbdr=1100 p_inc=%h idx=%0d",
                 k, {valid, busy, done, cfg_ready}, p_inc, step_idx, exp_p, idx);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_done();
    logic [31:0] exp_p;
    exp_p = m_start + m_step * 32'(m_nsteps - 1);
    tests++;
    if ({valid, busy, done, cfg_ready} !== 4'b0010 || p_inc !== exp_p ||
        step_idx !== 12'(m_nsteps - 1)) begin
      fails++;
      $display("[TB] FAIL done_cycle: vbdr=%b p_inc=%h idx=%0d, expected vbdr=0010 p_inc=%h idx=%0d",
               {valid, busy, done, cfg_ready}, p_inc, step_idx, exp_p, m_nsteps - 1);
    end
    @(negedge clk);
    tests++;
    if ({valid, busy, done, cfg_ready} !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL after_done: vbdr=%b expected 0001", {valid, busy, done, cfg_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests++;
    if ({valid, busy, done, cfg_ready, p_inc, step_idx} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: vbdr=%b p_inc=%h idx=%0d, expected all 0",
               {valid, busy, done, cfg_ready}, p_inc, step_idx);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (cfg_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ready_during_reset: got %b expected 0", cfg_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cfg_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ready_after_reset: got %b expected 1", cfg_ready);
    end
  endtask

  task automatic test_start_without_cfg();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({valid, busy, done, cfg_ready} !== 4'b0001) begin
        fails++;
        $display("[TB] FAIL start_no_cfg c%0d: vbdr=%b expected 0001", i, {valid, busy, done, cfg_ready});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic_sweep();
    do_cfg(32'h1000_0000, 32'h0100_0000, 4, 3, 1'b0, 1'b0);
    pulse_start();
    check_run(12);
    check_done();
  endtask

  task automatic test_wrap();
    do_cfg(32'hFFFF_FF00, 32'h0000_0200, 2, 1, 1'b0, 1'b1);
    check_run(2);
    check_done();
    do_cfg(32'd5, 32'hFFFF_FFFF, 3, 1, 1'b0, 1'b1);
    check_run(3);
    check_done();
  endtask

  task automatic test_zero_counts();
    do_cfg(32'h0ABC_0000, 32'h1, 0, 0, 1'b0, 1'b1);
    check_run(1);
    check_done();
  endtask

  task automatic test_abort();
    logic [31:0] exp_p;
    do_cfg(32'h2000_0000, 32'h0010_0000, 4, 2, 1'b0, 1'b1);
    check_run(4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_p = 32'h2020_0000;
    tests++;
    if ({valid, busy, done, cfg_ready} !== 4'b0001 || p_inc !== exp_p || step_idx !== 12'd2) begin
      fails++;
      $display("[TB] FAIL abort_mid: vbdr=%b p_inc=%h idx=%0d, expected vbdr=0001 p_inc=%h idx=2",
               {valid, busy, done, cfg_ready}, p_inc, step_idx, exp_p);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_mid_no_done: done=%b busy=%b expected 0 0", done, busy);
    end
    pulse_start();
    check_run(7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp_p = 32'h2030_0000;
    tests++;
    if ({valid, busy, done, cfg_ready} !== 4'b0001 || p_inc !== exp_p || step_idx !== 12'd3) begin
      fails++;
      $display("[TB] FAIL abort_last: vbdr=%b p_inc=%h idx=%0d, expected vbdr=0001 p_inc=%h idx=3",
               {valid, busy, done, cfg_ready}, p_inc, step_idx, exp_p);
    end
  endtask

  task automatic test_loop();
    do_cfg(32'h0400_0000, 32'h0000_4000, 2, 2, 1'b1, 1'b1);
    check_run(20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if ({valid, busy, done, cfg_ready} !== 4'b0001 || p_inc !== 32'h0400_0000) begin
      fails++;
      $display("[TB] FAIL loop_abort: vbdr=%b p_inc=%h, expected vbdr=0001 p_inc=04000000",
               {valid, busy, done, cfg_ready}, p_inc);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if ({valid, busy, done, cfg_ready} !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL abort_in_idle: vbdr=%b expected 0001", {valid, busy, done, cfg_ready});
    end
  endtask

  task automatic test_cfg_in_run();
    do_cfg(32'h0000_1000, 32'h0000_0010, 3, 2, 1'b0, 1'b0);
    pulse_start();
    cfg_start  = 32'hDEAD_0000;
    cfg_step   = 32'h0000_0777;
    cfg_nsteps = 12'd7;
    cfg_dwell  = 16'd5;
    cfg_valid  = 1'b1;
    start      = 1'b1;
    check_run(6);
    cfg_valid = 1'b0;
    start     = 1'b0;
    check_done();
    pulse_start();
    check_run(6);
    check_done();
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int n;
      int d;
      n = $urandom_range(0, 5);
      d = $urandom_range(0, 4);
      do_cfg($urandom, $urandom, n, d, 1'b0, 1'($urandom_range(0, 1)));
      if (busy !== 1'b1) pulse_start();
      check_run(m_nsteps * m_dwell);
      check_done();
    end
  endtask

  task automatic test_reset_midrun();
    do_cfg(32'h3000_0000, 32'h0000_0100, 5, 3, 1'b0, 1'b1);
    check_run(5);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({valid, busy, done, cfg_ready, p_inc, step_idx} !== '0) begin
      fails++;
      $display("[TB] FAIL async_reset_midrun: vbdr=%b p_inc=%h idx=%0d, expected all 0",
               {valid, busy, done, cfg_ready}, p_inc, step_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    tests++;
    if ({valid, busy, done, cfg_ready} !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL start_after_reset: vbdr=%b expected 0001", {valid, busy, done, cfg_ready});
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_start  = '0;
    cfg_step   = '0;
    cfg_nsteps = '0;
    cfg_dwell  = '0;
    cfg_loop   = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    test_reset();
    test_start_without_cfg();
    test_basic_sweep();
    test_wrap();
    test_zero_counts();
    test_abort();
    test_loop();
    test_cfg_in_run();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
